reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
// - Shares one 4-bit enable-loaded register (D flip-flops with enable) among NREQ requesters.
// - Round-robin grant; drives the register's en/din; reads its qout back to confirm each write.
// - Retries on mismatch; reports success or failure per transaction through a req/ack handshake.
// - Sits between requesting datapath units and the shared register instance.
// PARAMETERS
// - NREQ      4  number of requesters (2..8)
// - WIDTH     4  register data width
// - MAX_RETRY 2  extra write attempts after the first mismatch before failing
// PORTS
// - clk       in   1            single clock; all state changes on rising edge
// - rst       in   1            synchronous reset, active-low (rst==0 at a rising edge resets)
// - req       in   NREQ         per-requester write request; level, held until ack
// - wdata     in   NREQ*WIDTH   flattened write data; slice i = wdata[i*WIDTH +: WIDTH]
// - ack       out  NREQ         one-hot, one-cycle pulse to the owning requester at completion
// - err       out  1            qualifies ack: 1 = write failed after retries
// - reg_en    out  1            to register en
// - reg_din   out  WIDTH        to register din
// - reg_qout  in   WIDTH        from register qout
// - owner     out  clog2(NREQ)  index of the current grantee (valid while busy)
// - busy      out  1            1 in every state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, owner=0, retry_cnt=0, latched data=0; ack=0, err=0, reg_en=0,
//   reg_din=0, busy=0. Reset mid-transaction abandons it: no ack, reg_en drops next cycle.
// - FSM states: IDLE, WRITE, VERIFY, DONE.
// - IDLE: if any req, pick first set bit at or after rr_ptr (wrapping NREQ-1 -> 0); latch
//   owner and wdata slice; retry_cnt=0; -> WRITE. No req: stay.
// - WRITE (1 cycle): reg_en=1, reg_din=latched data; -> VERIFY.
// - VERIFY (1 cycle): compare reg_qout to latched data.
//   match -> DONE(ok); mismatch and retry_cnt<MAX_RETRY -> retry_cnt+1, WRITE;
//   mismatch and retry_cnt==MAX_RETRY -> DONE(fail).
// - DONE (1 cycle): ack[owner]=1; err=1 on fail, else 0; rr_ptr=owner+1 mod NREQ; -> IDLE.
// - Latency: req seen high at edge k -> reg_en high in cycle k+1 -> ack in cycle k+3;
//   4 cycles per clean transaction; each retry adds 2.
// - reg_en, reg_din, ack, err are registered state decodes; reg_en=0 outside WRITE;
//   reg_din holds latched data from WRITE until the next grant.
// - Data and owner latch at grant; later wdata or req changes do not affect the transaction.
// - Requester dropping req mid-transaction: transaction still completes and ack still pulses.
// - Requester must drop req the cycle after ack; req still high in IDLE is a new request.
// - Simultaneous requests: exactly one grant per IDLE visit; round-robin prevents starvation.
// - The arbiter never drives the register's reset; a reg_qout change outside VERIFY is ignored.
// STRUCTURE
// - Shared package: state encoding (IDLE=2'd0, WRITE=2'd1, VERIFY=2'd2, DONE=2'd3) and
//   defaults of NREQ, WIDTH, MAX_RETRY.
// - One sub-module: rr_pick (combinational): inputs req and rr_ptr; outputs found and idx.
// - Top level: FSM, latches, retry counter, output registers.
// TESTING
// - Reset: hold rst=0 3 cycles with req=4'b1111 -> busy=0, reg_en=0, ack=0 throughout;
//   first grant after release goes to requester 0.
// - Single write: req=4'b0100, slice2=4'hA, real register model -> reg_en in cycle k+1 with
//   reg_din=4'hA; ack=4'b0100, err=0 in cycle k+3.
// - Contention: req=4'b1011 held, each requester drops req after its ack -> grants in order
//   0, 1, 3; then req0 re-raised -> served next (rr wrap 3 -> 0).
// - Stuck bit: model forces qout[1]=0, requester 1 writes 4'hF -> 3 WRITE pulses
//   (1+MAX_RETRY); ack=4'b0010 with err=1 at cycle k+7.
// - Abort: rst=0 in the VERIFY cycle -> next cycle IDLE, no ack, rr_ptr=0.
// - Late change: wdata/req altered during WRITE -> VERIFY compares latched data; ack still issued.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter: state encoding and
// default sizing.
package reg_write_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WRITE  = 2'd1;
    localparam state_t ST_VERIFY = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX_RETRY = 2;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Round-robin picker: finds the first asserted request at or after rr_ptr,
// wrapping from NREQ-1 back to 0. Purely combinational.
module reg_write_arbiter_rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand [NREQ];
    logic [NREQ-1:0] hit;

    // Candidate index for each offset from the pointer, reduced modulo NREQ
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum         = {1'b0, rr_ptr} + (IW+1)'(gi);
            assign cand[gi]    = (sum >= (IW+1)'(NREQ)) ? (IW)'(sum - (IW+1)'(NREQ))
                                                        : sum[IW-1:0];
            assign hit[gi]     = req[cand[gi]];
        end
    endgenerate

    // Lowest offset with a pending request wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found = 1'b1;
                idx   = cand[i];
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates write access to one shared enable-loaded register among NREQ
// requesters. Each granted write is read back the cycle after it is
// issued and retried up to MAX_RETRY extra times before reporting failure.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter  int NREQ      = DEF_NREQ,
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int MAX_RETRY = DEF_MAX_RETRY,
    localparam int IW        = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         ack,
    output logic                    err,
    output logic                    reg_en,
    output logic [WIDTH-1:0]        reg_din,
    input  logic [WIDTH-1:0]        reg_qout,
    output logic [IW-1:0]           owner,
    output logic                    busy
);

    // Counter wide enough to hold MAX_RETRY, including the MAX_RETRY=0 case
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t            state_reg;
    logic [IW-1:0]     rr_ptr_reg;
    logic [IW-1:0]     owner_reg;
    logic [RW-1:0]     retry_cnt_reg;
    logic [WIDTH-1:0]  data_reg;
    logic [NREQ-1:0]   ack_reg;
    logic              err_reg;
    logic              reg_en_reg;
    logic [WIDTH-1:0]  reg_din_reg;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [WIDTH-1:0]  wslice [NREQ];

    // Unpack the flattened write data into per-requester slices
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign wslice[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    reg_write_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // FSM with registered outputs; reg_en/ack/err are one-cycle pulses
    // decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            retry_cnt_reg <= '0;
            data_reg      <= '0;
            ack_reg       <= '0;
            err_reg       <= 1'b0;
            reg_en_reg    <= 1'b0;
            reg_din_reg   <= '0;
        end else begin
            ack_reg    <= '0;
            err_reg    <= 1'b0;
            reg_en_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner_reg     <= pick_idx;
                        data_reg      <= wslice[pick_idx];
                        retry_cnt_reg <= '0;
                        reg_en_reg    <= 1'b1;
                        reg_din_reg   <= wslice[pick_idx];
                        state_reg     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    state_reg <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (reg_qout == data_reg) begin
                        ack_reg   <= (NREQ)'(1) << owner_reg;
                        state_reg <= ST_DONE;
                    end else if (retry_cnt_reg < (RW)'(MAX_RETRY)) begin
                        retry_cnt_reg <= retry_cnt_reg + (RW)'(1);
                        reg_en_reg    <= 1'b1;
                        reg_din_reg   <= data_reg;
                        state_reg     <= ST_WRITE;
                    end else begin
                        ack_reg   <= (NREQ)'(1) << owner_reg;
                        err_reg   <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rr_ptr_reg <= (owner_reg == (IW)'(NREQ - 1)) ? '0
                                                                 : owner_reg + (IW)'(1);
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack     = ack_reg;
    assign err     = err_reg;
    assign reg_en  = reg_en_reg;
    assign reg_din = reg_din_reg;
    assign owner   = owner_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural model of the
// shared enable-loaded register (optionally with stuck-at-0 bits).
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  ack;
    logic        err;
    logic        reg_en;
    logic [3:0]  reg_din;
    logic [3:0]  reg_qout;
    logic [1:0]  owner;
    logic        busy;

    logic [3:0]  q_reg = 4'h0;
    logic [3:0]  stuck_mask = 4'h0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Shared register: loads din when en is high, optional stuck-at-0 bits
    always @(posedge clk) begin
        if (reg_en) q_reg <= reg_din;
    end
    assign reg_qout = q_reg & ~stuck_mask;

    reg_write_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .ack      (ack),
        .err      (err),
        .reg_en   (reg_en),
        .reg_din  (reg_din),
        .reg_qout (reg_qout),
        .owner    (owner),
        .busy     (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        req   = 4'b1111;
        wdata = 16'h4321;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || reg_en !== 1'b0 || ack !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold: busy=%b reg_en=%b ack=%b required 0/0/0000", busy, reg_en, ack);
            end
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (reg_en !== 1'b1 || owner !== 2'd0 || reg_din !== 4'h1) begin
            n_fail++;
            $display("FAIL reset_first_grant: reg_en=%b owner=%0d din=%h required 1/0/1", reg_en, owner, reg_din);
        end
        tick();
        tick();
        n_checks++;
        if (ack !== 4'b0001 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_ack: ack=%b err=%b required 0001/0", ack, err);
        end
        $display("txn reset: owner=%0d ack=%b err=%b", owner, ack, err);
        req = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        req   = 4'b0100;
        wdata = 16'h0A00;
        tick();
        n_checks++;
        if (reg_en !== 1'b1 || reg_din !== 4'hA || owner !== 2'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write: reg_en=%b din=%h owner=%0d busy=%b required 1/a/2/1", reg_en, reg_din, owner, busy);
        end
        tick();
        n_checks++;
        if (reg_en !== 1'b0 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_verify: reg_en=%b ack=%b required 0/0000", reg_en, ack);
        end
        tick();
        n_checks++;
        if (ack !== 4'b0100 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b err=%b required 0100/0", ack, err);
        end
        $display("txn single: owner=%0d ack=%b err=%b q=%h", owner, ack, err, q_reg);
        req = 4'b0000;
        tick();
        n_checks++;
        if (busy !== 1'b0 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b ack=%b required 0/0000", busy, ack);
        end
    endtask

    task automatic test_stuck_bit();
        int pulses = 0;
        stuck_mask = 4'b0010;
        req        = 4'b0010;
        wdata      = 16'h00F0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (reg_en === 1'b1) pulses++;
            if (c < 7) begin
                n_checks++;
                if (ack !== 4'b0000 || reg_en !== ((c % 2) == 1)) begin
                    n_fail++;
                    $display("FAIL stuck_cycle%0d: ack=%b reg_en=%b required 0000/%b", c, ack, reg_en, (c % 2) == 1);
                end
            end
        end
        n_checks++;
        if (ack !== 4'b0010 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_ack: ack=%b err=%b required 0010/1", ack, err);
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL stuck_pulses: got %0d required 3", pulses);
        end
        $display("txn stuck: owner=%0d ack=%b err=%b writes=%0d", owner, ack, err, pulses);
        req        = 4'b0000;
        stuck_mask = 4'b0000;
        tick();
    endtask

    task automatic test_abort();
        req   = 4'b0001;
        wdata = 16'h0007;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || ack !== 4'b0000 || reg_en !== 1'b0 || reg_din !== 4'h0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b ack=%b reg_en=%b din=%h owner=%0d required 0/0000/0/0/0",
                     busy, ack, reg_en, reg_din, owner);
        end
        rst = 1'b1;
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (ack !== 4'b0000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet: ack=%b busy=%b required 0000/0", ack, busy);
            end
        end
        $display("txn abort: abandoned, ack=%b busy=%b", ack, busy);
    endtask

    task automatic serve_one(input logic [1:0] exp_owner, input logic [3:0] exp_data, input string tag);
        int n = 0;
        while (ack === 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (ack !== (4'b0001 << exp_owner) || err !== 1'b0 || owner !== exp_owner || q_reg !== exp_data) begin
            n_fail++;
            $display("FAIL %s: ack=%b err=%b owner=%0d q=%h required %b/0/%0d/%h",
                     tag, ack, err, owner, q_reg, 4'b0001 << exp_owner, exp_owner, exp_data);
        end
        $display("txn %s: owner=%0d ack=%b err=%b q=%h", tag, owner, ack, err, q_reg);
        req[exp_owner] = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        wdata = 16'h8521;
        req   = 4'b1011;
        serve_one(2'd0, 4'h1, "contend_0");
        serve_one(2'd1, 4'h2, "contend_1");
        serve_one(2'd3, 4'h8, "contend_3");
        req = 4'b0011;
        serve_one(2'd0, 4'h1, "wrap_0");
        serve_one(2'd1, 4'h2, "wrap_1");
    endtask

    task automatic test_late_change();
        req   = 4'b0100;
        wdata = 16'h0500;
        tick();
        n_checks++;
        if (reg_en !== 1'b1 || reg_din !== 4'h5) begin
            n_fail++;
            $display("FAIL late_write: reg_en=%b din=%h required 1/5", reg_en, reg_din);
        end
        wdata = 16'h0300;
        req   = 4'b0000;
        tick();
        tick();
        n_checks++;
        if (ack !== 4'b0100 || err !== 1'b0 || q_reg !== 4'h5) begin
            n_fail++;
            $display("FAIL late_ack: ack=%b err=%b q=%h required 0100/0/5", ack, err, q_reg);
        end
        $display("txn late: owner=%0d ack=%b err=%b q=%h", owner, ack, err, q_reg);
        tick();
        n_checks++;
        if (busy !== 1'b0 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL late_idle: busy=%b ack=%b required 0/0000", busy, ack);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stuck_bit();
        test_abort();
        test_contention();
        test_late_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
